// File: rtl/ppu_sprite_scheduler_if.sv
// OAM read port and pattern-memory request/acknowledge port of the sprite scheduler.
// Latency: OAM data returns one cycle after oam_addr; a pattern byte is valid in the cycle pat_ack is high.
// Backpressure: pat_req/pat_addr are held by the master until the slave raises pat_ack.
interface ppu_sprite_scheduler_if;
    logic [7:0]  oam_addr;   // OAM byte address
    logic [7:0]  oam_data;   // OAM read data, one cycle after oam_addr
    logic        pat_req;    // pattern byte request
    logic [12:0] pat_addr;   // pattern byte address
    logic        pat_ack;    // request accepted, pat_data valid this cycle
    logic [7:0]  pat_data;   // pattern byte

    modport master (
        output oam_addr,
        input  oam_data,
        output pat_req,
        output pat_addr,
        input  pat_ack,
        input  pat_data
    );

    modport slave (
        input  oam_addr,
        output oam_data,
        input  pat_req,
        input  pat_addr,
        output pat_ack,
        output pat_data
    );
endinterface

// File: rtl/ppu_sprite_scheduler.sv
// Per-scanline sprite evaluation (OAM scan, up to 3 slots) and pattern fetch for the PPU pixel path.
// Latency: 2 cycles per rejected sprite, 8 per accepted sprite, >=1 cycle per pattern byte; outputs commit on scanline_start.
// Backpressure: pattern fetch stalls with pat_req/pat_addr held until pat_ack; scanline_start abandons any fetch in flight.
//
// Ports: clk/rst (sync, active-high); scanline_start_i/scanline_i/sprite_size_16_i/sprite_table_i per-line controls;
//   mem (master modport): OAM address/data and pattern req/addr/ack/data;
//   slot_*_o: committed per-slot pattern, attribute, X and valid (slot k in bits [8k+7:8k]);
//   sprite0_in_slot0_o, sprite_overflow_o, busy_o.
// Build option: define SPRITE_FLIP_EN to honour attr[7] (vertical flip) and attr[6] (horizontal flip) during fetch.
module ppu_sprite_scheduler #(
    parameter int NUM_SPRITES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scanline_start_i,
    input  logic [7:0]               scanline_i,
    input  logic                     sprite_size_16_i,
    input  logic                     sprite_table_i,
    ppu_sprite_scheduler_if.master   mem,
    output logic [23:0]              slot_pattern_low_o,
    output logic [23:0]              slot_pattern_high_o,
    output logic [23:0]              slot_attr_o,
    output logic [23:0]              slot_x_o,
    output logic [2:0]               slot_valid_o,
    output logic                     sprite0_in_slot0_o,
    output logic                     sprite_overflow_o,
    output logic                     busy_o
);

`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    localparam logic [5:0] LAST_N = 6'(NUM_SPRITES - 1);

    typedef enum logic [2:0] {
        IDLE, Y_ADDR, Y_DATA, C_ADDR, C_DATA, F_LO, F_HI
    } state_t;

    state_t      state_q;
    logic [5:0]  n_q;          // OAM sprite index under evaluation
    logic [1:0]  b_q;          // OAM byte being copied (1 tile, 2 attr, 3 X)
    logic [1:0]  cnt_q;        // sprites accepted so far
    logic [1:0]  s_q;          // slot being fetched
    logic [7:0]  line_q;
    logic        size16_q;
    logic        table_q;

    logic [7:0]  sh_tile_q [3];
    logic [7:0]  sh_attr_q [3];
    logic [7:0]  sh_x_q    [3];
    logic [3:0]  sh_row_q  [3];
    logic [7:0]  sh_lo_q   [3];
    logic [7:0]  sh_hi_q   [3];
    logic [2:0]  sh_valid_q;
    logic        sh_s0_q;
    logic        sh_ovf_q;

    logic [7:0]  oam_addr_q;
    logic        pat_req_q;
    logic [12:0] pat_addr_q;

    // LO-plane byte address for one slot; HI plane is this with bit 3 set.
    function automatic logic [12:0] lo_addr(input logic [7:0] tile, input logic [7:0] attr,
                                            input logic [3:0] row_raw, input logic size16,
                                            input logic tbl);
        logic [3:0] row;
        row = row_raw;
        if (FLIP_EN && attr[7])
            row = size16 ? (4'd15 - row_raw) : (4'd7 - row_raw);
        if (size16)
            lo_addr = {tile[0], tile[7:1], row[3], 1'b0, row[2:0]};
        else
            lo_addr = {tbl, tile, 1'b0, row[2:0]};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    logic [8:0]  diff_d;
    logic        in_range_d;
    logic        n_last_d;
    logic [1:0]  cnt_inc_d;
    logic [1:0]  s_inc_d;
    logic [12:0] first_addr_d;
    logic [12:0] next_addr_d;
    logic [7:0]  pat_byte_d;

    always_comb begin
        // 9-bit subtract: bit 8 is the borrow, so sprites below the line never match.
        diff_d       = {1'b0, line_q} - {1'b0, mem.oam_data};
        in_range_d   = !diff_d[8] && (diff_d[7:0] < (size16_q ? 8'd16 : 8'd8));
        n_last_d     = (n_q == LAST_N);
        cnt_inc_d    = cnt_q + 2'd1;
        s_inc_d      = s_q + 2'd1;
        first_addr_d = lo_addr(sh_tile_q[0], sh_attr_q[0], sh_row_q[0], size16_q, table_q);
        next_addr_d  = lo_addr(sh_tile_q[s_inc_d], sh_attr_q[s_inc_d], sh_row_q[s_inc_d],
                               size16_q, table_q);
        pat_byte_d   = (FLIP_EN && sh_attr_q[s_q][6]) ? rev8(mem.pat_data) : mem.pat_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            s_q        <= '0;
            line_q     <= '0;
            size16_q   <= 1'b0;
            table_q    <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                sh_tile_q[k] <= '0;
                sh_attr_q[k] <= '0;
                sh_x_q[k]    <= '0;
                sh_row_q[k]  <= '0;
                sh_lo_q[k]   <= '0;
                sh_hi_q[k]   <= '0;
            end
            sh_valid_q          <= '0;
            sh_s0_q             <= 1'b0;
            sh_ovf_q            <= 1'b0;
            oam_addr_q          <= '0;
            pat_req_q           <= 1'b0;
            pat_addr_q          <= '0;
            slot_pattern_low_o  <= '0;
            slot_pattern_high_o <= '0;
            slot_attr_o         <= '0;
            slot_x_o            <= '0;
            slot_valid_o        <= '0;
            sprite0_in_slot0_o  <= 1'b0;
            sprite_overflow_o   <= 1'b0;
        end else if (scanline_start_i) begin
            // Commit: a slot whose HI byte never arrived shows an empty (zero) pattern.
            for (int k = 0; k < 3; k++) begin
                slot_pattern_low_o[8*k +: 8]  <= sh_valid_q[k] ? sh_lo_q[k] : 8'h00;
                slot_pattern_high_o[8*k +: 8] <= sh_valid_q[k] ? sh_hi_q[k] : 8'h00;
                slot_attr_o[8*k +: 8]         <= sh_attr_q[k];
                slot_x_o[8*k +: 8]            <= sh_x_q[k];
                sh_tile_q[k] <= '0;
                sh_attr_q[k] <= '0;
                sh_x_q[k]    <= '0;
                sh_row_q[k]  <= '0;
                sh_lo_q[k]   <= '0;
                sh_hi_q[k]   <= '0;
            end
            slot_valid_o       <= sh_valid_q;
            sprite0_in_slot0_o <= sh_s0_q;
            sprite_overflow_o  <= sh_ovf_q;
            sh_valid_q         <= '0;
            sh_s0_q            <= 1'b0;
            sh_ovf_q           <= 1'b0;
            state_q            <= Y_ADDR;
            n_q                <= '0;
            b_q                <= '0;
            cnt_q              <= '0;
            s_q                <= '0;
            line_q             <= scanline_i;
            size16_q           <= sprite_size_16_i;
            table_q            <= sprite_table_i;
            oam_addr_q         <= '0;
            pat_req_q          <= 1'b0;
            pat_addr_q         <= '0;
        end else begin
            case (state_q)
                IDLE: ;
                Y_ADDR: state_q <= Y_DATA;
                Y_DATA: begin
                    if (in_range_d && cnt_q != 2'd3) begin
                        sh_row_q[cnt_q] <= diff_d[3:0];
                        b_q             <= 2'd1;
                        oam_addr_q      <= {n_q, 2'd1};
                        state_q         <= C_ADDR;
                    end else if (in_range_d) begin
                        // Fourth hit: only the overflow flag matters, start fetching.
                        sh_ovf_q   <= 1'b1;
                        s_q        <= '0;
                        pat_req_q  <= 1'b1;
                        pat_addr_q <= first_addr_d;
                        state_q    <= F_LO;
                    end else if (n_last_d) begin
                        if (cnt_q == 2'd0) begin
                            state_q <= IDLE;
                        end else begin
                            s_q        <= '0;
                            pat_req_q  <= 1'b1;
                            pat_addr_q <= first_addr_d;
                            state_q    <= F_LO;
                        end
                    end else begin
                        n_q        <= n_q + 6'd1;
                        oam_addr_q <= {n_q + 6'd1, 2'b00};
                        state_q    <= Y_ADDR;
                    end
                end
                C_ADDR: state_q <= C_DATA;
                C_DATA: begin
                    case (b_q)
                        2'd1:    sh_tile_q[cnt_q] <= mem.oam_data;
                        2'd2:    sh_attr_q[cnt_q] <= mem.oam_data;
                        default: sh_x_q[cnt_q]    <= mem.oam_data;
                    endcase
                    if (b_q != 2'd3) begin
                        b_q        <= b_q + 2'd1;
                        oam_addr_q <= {n_q, b_q + 2'd1};
                        state_q    <= C_ADDR;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        if (n_q == 6'd0) sh_s0_q <= 1'b1;
                        // With three slots full the scan goes on purely to detect overflow.
                        if (n_last_d) begin
                            s_q        <= '0;
                            pat_req_q  <= 1'b1;
                            pat_addr_q <= first_addr_d;
                            state_q    <= F_LO;
                        end else begin
                            n_q        <= n_q + 6'd1;
                            oam_addr_q <= {n_q + 6'd1, 2'b00};
                            state_q    <= Y_ADDR;
                        end
                    end
                end
                F_LO: begin
                    if (mem.pat_ack) begin
                        sh_lo_q[s_q] <= pat_byte_d;
                        pat_addr_q   <= pat_addr_q | 13'h0008;
                        state_q      <= F_HI;
                    end
                end
                F_HI: begin
                    if (mem.pat_ack) begin
                        sh_hi_q[s_q]    <= pat_byte_d;
                        sh_valid_q[s_q] <= 1'b1;
                        if (s_q == cnt_q - 2'd1) begin
                            pat_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            s_q        <= s_inc_d;
                            pat_addr_q <= next_addr_d;
                            state_q    <= F_LO;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.oam_addr = oam_addr_q;
    assign mem.pat_req  = pat_req_q;
    assign mem.pat_addr = pat_addr_q;
    assign busy_o       = (state_q != IDLE);

endmodule
